// File: rtl/asfifo_wr_packer.sv
// Write-side producer for the 16-bit async FIFO: splits each accepted 2*W-bit word
// into two FIFO beats (low half first) and tracks burst completion and stalls.
module asfifo_wr_packer #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_data,
  input  logic             in_last,
  input  logic             abort,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [W-1:0]     fifo_wr_data,
  output logic             burst_done,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [2*W-1:0]   hold_r;
  logic             last_r;
  logic             accept_s;
  logic             hi_push_s;
  logic             stall_s;
  logic             burst_done_r;
  logic [CNT_W-1:0] word_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  assign accept_s  = in_valid & in_ready;
  assign hi_push_s = (state_r == HI) & fifo_wr_en;
  assign stall_s   = ((state_r == LO) | (state_r == HI)) & fifo_full;

  assign burst_done = burst_done_r;
  assign word_cnt   = word_cnt_r;
  assign stall_cnt  = stall_cnt_r;

  // State register
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = accept_s ? LO : IDLE;
        LO:   state_nxt_s = fifo_wr_en ? HI : LO;
        HI: begin
          if (fifo_wr_en) begin
            state_nxt_s = accept_s ? LO : IDLE;
          end else begin
            state_nxt_s = HI;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Handshake and FIFO write port, never enabled while full
  always_comb begin
    fifo_wr_en   = 1'b0;
    fifo_wr_data = {W{1'b0}};
    in_ready     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = ~abort;
      end
      LO: begin
        fifo_wr_data = hold_r[W-1:0];
        fifo_wr_en   = ~fifo_full & ~abort;
      end
      HI: begin
        fifo_wr_data = hold_r[2*W-1:W];
        fifo_wr_en   = ~fifo_full & ~abort;
        in_ready     = ~fifo_full & ~abort;
      end
      default: begin
        fifo_wr_en = 1'b0;
      end
    endcase
  end

  // Hold register and last flag
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      hold_r <= {(2*W){1'b0}};
      last_r <= 1'b0;
    end else if (abort) begin
      hold_r <= {(2*W){1'b0}};
      last_r <= 1'b0;
    end else if (accept_s) begin
      hold_r <= in_data;
      last_r <= in_last;
    end
  end

  // Burst completion pulse and per-burst word count
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      burst_done_r <= 1'b0;
      word_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      burst_done_r <= hi_push_s & last_r;
      if (abort) begin
        word_cnt_r <= {CNT_W{1'b0}};
      end else if (hi_push_s) begin
        word_cnt_r <= last_r ? {CNT_W{1'b0}} : word_cnt_r + CNT_W'(1);
      end
    end
  end

  // Saturating stall counter, cleared only by reset
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

endmodule
